bus_uart_tx: RTL

Memory-mapped UART transmitter that sits directly downstream of the PicoRV32 memory/IO decode, next to on-chip RAM and the LED register. It consumes CPU bus writes at its address window, buffers bytes in a small FIFO and serialises them as 8N1 on a tx pin. It answers on the same valid/ready bus the core drives, and the top-level ORs its mem_ready/mem_rdata with the other slaves.

---
 rtl/bus_uart_pkg.sv | 28 ++
 rtl/bus_uart_fifo.sv | 59 +++++
 rtl/bus_uart_tx.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/bus_uart_pkg.sv
// rtl/bus_uart_pkg.sv - shared constants and types for the bus UART transmitter
package bus_uart_pkg;

  localparam int DIV_W = 16;

  localparam logic [1:0] REG_DIV    = 2'd0;
  localparam logic [1:0] REG_DATA   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam int STATUS_BUSY    = 0;
  localparam int STATUS_FULL    = 1;
  localparam int STATUS_EMPTY   = 2;
  localparam int STATUS_CNT_LSB = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  // Bit periods below two cycles are not usable, so the latched divider is floored.
  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
    return (d < DIV_W'(2)) ? DIV_W'(2) : d;
  endfunction

endpackage

// File: rtl/bus_uart_fifo.sv
// rtl/bus_uart_fifo.sv - synchronous show-ahead FIFO with occupancy count
module bus_uart_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers are exactly log2(DEPTH) wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_uart_tx.sv
// rtl/bus_uart_tx.sv - memory-mapped 8N1 UART transmitter on the PicoRV32 valid/ready bus
module bus_uart_tx
  import bus_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
  parameter int          FIFO_DEPTH  = 8,
  parameter int          DEFAULT_DIV = 104
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        tx,
  output logic        fifo_empty
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [DIV_W-1:0] div;
  logic [CW-1:0]    q_count;
  logic             q_full;
  logic             q_empty;
  logic [7:0]       q_rdata;
  logic             push;
  logic             pop;

  logic             hit;
  logic             is_write;
  logic             data_push_req;
  logic             stall;
  logic             take;
  logic [1:0]       reg_off;
  logic [7:0]       count8;
  logic [31:0]      status;
  logic [31:0]      rdata_n;

  tx_state_t        state;
  tx_state_t        state_n;
  logic [7:0]       shreg;
  logic [2:0]       bit_idx;
  logic [DIV_W-1:0] bit_cnt;
  logic [DIV_W-1:0] eff_div;
  logic [DIV_W-1:0] div_latch;
  logic             tick;

  logic             unused;
  assign unused = ^{mem_addr[1:0], mem_wdata[31:16]};

  assign hit           = (mem_addr[31:4] == BASE_ADDR[31:4]);
  assign reg_off       = mem_addr[3:2];
  assign is_write      = |mem_wstrb;
  assign data_push_req = is_write && (reg_off == REG_DATA) && mem_wstrb[0];
  // A push into a full FIFO is held off entirely; the request is taken once room appears.
  assign stall         = data_push_req && q_full;
  assign take          = resetn && mem_valid && !mem_ready && hit && !stall;
  assign push          = take && data_push_req;
  assign count8        = 8'(q_count);

  always_comb begin
    status = '0;
    status[STATUS_BUSY]              = (state != ST_IDLE);
    status[STATUS_FULL]              = q_full;
    status[STATUS_EMPTY]             = q_empty;
    status[STATUS_CNT_LSB +: 8]      = count8;
  end

  always_comb begin
    rdata_n = '0;
    if (!is_write) begin
      case (reg_off)
        REG_DIV:    rdata_n = {16'b0, div};
        REG_DATA:   rdata_n = status;
        REG_STATUS: rdata_n = status;
        default:    rdata_n = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      div       <= DIV_W'(DEFAULT_DIV);
    end else begin
      mem_ready <= take;
      mem_rdata <= take ? rdata_n : '0;
      if (take && is_write && (reg_off == REG_DIV)) begin
        if (mem_wstrb[0]) begin
          div[7:0] <= mem_wdata[7:0];
        end
        if (mem_wstrb[1]) begin
          div[15:8] <= mem_wdata[15:8];
        end
      end
    end
  end

  bus_uart_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .wdata  (mem_wdata[7:0]),
    .pop    (pop),
    .rdata  (q_rdata),
    .full   (q_full),
    .empty  (q_empty),
    .count  (q_count)
  );

  assign tick       = (bit_cnt == '0);
  assign div_latch  = clamp_div(div);
  assign fifo_empty = q_empty && (state == ST_IDLE);

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    tx      = 1'b1;
    case (state)
      ST_IDLE: begin
        if (!q_empty) begin
          pop     = 1'b1;
          state_n = ST_START;
        end
      end
      ST_START: begin
        tx = 1'b0;
        if (tick) begin
          state_n = ST_DATA;
        end
      end
      ST_DATA: begin
        tx = shreg[0];
        if (tick && (bit_idx == 3'd7)) begin
          state_n = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (!q_empty) begin
            pop     = 1'b1;
            state_n = ST_START;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      bit_idx <= '0;
      bit_cnt <= '0;
      eff_div <= DIV_W'(2);
    end else begin
      state <= state_n;
      // The divider is sampled only at a pop, so mid-frame DIV writes wait for the next byte.
      if (pop) begin
        shreg   <= q_rdata;
        eff_div <= div_latch;
        bit_cnt <= div_latch - DIV_W'(1);
        bit_idx <= '0;
      end else if (state != ST_IDLE) begin
        if (tick) begin
          bit_cnt <= eff_div - DIV_W'(1);
          if (state == ST_DATA) begin
            shreg   <= {1'b0, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
          end
        end else begin
          bit_cnt <= bit_cnt - DIV_W'(1);
        end
      end
    end
  end

endmodule
